// File: rtl/interrupt_ctrl.sv
// Interrupt controller: latches IRQ pulses into IF, masks with IE, gates with IME,
// and runs the CPU dispatch handshake that hands back a fixed-priority vector.
//
// state  | meaning
// IDLE   | no dispatch in progress, INT_ACK takes a vector
// VECTOR | vector registered and held until IME_SET, further INT_ACKs ignored
module interrupt_ctrl #(
    parameter int          NUM_SRC    = 5,
    parameter logic [7:0]  VEC_BASE   = 8'h40,
    parameter logic [7:0]  VEC_STRIDE = 8'h08,
    parameter logic [15:0] IF_ADDR    = 16'hFF0F,
    parameter logic [15:0] IE_ADDR    = 16'hFFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] ADDR,
    input  logic        WR,
    input  logic        RD,
    input  logic [7:0]  MMIO_DATA_out,
    output logic [7:0]  MMIO_DATA_in,
    input  logic        IRQ_VBLANK,
    input  logic        IRQ_LCDC,
    input  logic        IRQ_TIMER,
    input  logic        IRQ_SERIAL,
    input  logic        IRQ_JOYPAD,
    input  logic        IME_SET,
    input  logic        IME_CLR,
    input  logic        INT_ACK,
    output logic        INT_PENDING,
    output logic        INT_REQ,
    output logic [7:0]  INT_VEC,
    output logic        INT_VEC_VALID
);

    localparam int IDX_W = $clog2(NUM_SRC);

    typedef enum logic {IDLE, VECTOR} state_t;

    state_t             state;
    logic [NUM_SRC-1:0] if_q;
    logic [NUM_SRC-1:0] if_next;
    logic [NUM_SRC-1:0] irq_vec;
    logic [NUM_SRC-1:0] pending;
    logic [7:0]         ie_q;
    logic               ime_q;
    logic [IDX_W-1:0]   idx;
    logic               ack_take;
    logic               wr_if;
    logic               wr_ie;
    logic [7:0]         vec_next;
    logic               unused_rd;

    assign unused_rd   = RD;
    assign irq_vec     = {IRQ_JOYPAD, IRQ_SERIAL, IRQ_TIMER, IRQ_LCDC, IRQ_VBLANK};
    assign pending     = if_q & ie_q[NUM_SRC-1:0];
    assign INT_PENDING = |pending;
    assign INT_REQ     = INT_PENDING & ime_q;
    assign ack_take    = INT_ACK && (state == IDLE);
    assign wr_if       = WR && (ADDR == IF_ADDR);
    assign wr_ie       = WR && (ADDR == IE_ADDR);

    // scan from the top so the lowest set bit (highest priority) wins
    always_comb begin
        idx = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (pending[i]) idx = IDX_W'(i);
        end
    end

    assign vec_next = INT_PENDING ? (VEC_BASE + 8'(idx) * VEC_STRIDE) : 8'h00;

    // CPU write first, then the dispatch clear, then new pulses so none are lost
    always_comb begin
        if_next = if_q;
        if (wr_if) if_next = MMIO_DATA_out[NUM_SRC-1:0];
        if (ack_take && INT_PENDING) if_next = if_next & ~(NUM_SRC'(1) << idx);
        if_next = if_next | irq_vec;
    end

    always_comb begin
        MMIO_DATA_in = 8'hFF;
        if (ADDR == IF_ADDR)      MMIO_DATA_in = {{(8-NUM_SRC){1'b1}}, if_q};
        else if (ADDR == IE_ADDR) MMIO_DATA_in = ie_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            if_q          <= '0;
            ie_q          <= 8'h00;
            ime_q         <= 1'b0;
            INT_VEC       <= 8'h00;
            INT_VEC_VALID <= 1'b0;
        end else begin
            if_q <= if_next;
            if (wr_ie) ie_q <= MMIO_DATA_out;

            if (IME_CLR)       ime_q <= 1'b0;
            else if (ack_take) ime_q <= 1'b0;
            else if (IME_SET)  ime_q <= 1'b1;

            case (state)
                IDLE: begin
                    if (INT_ACK) begin
                        state         <= VECTOR;
                        INT_VEC       <= vec_next;
                        INT_VEC_VALID <= 1'b1;
                    end else if (IME_SET) begin
                        INT_VEC_VALID <= 1'b0;
                    end
                end
                VECTOR: begin
                    if (IME_SET) begin
                        state         <= IDLE;
                        INT_VEC_VALID <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
